serial_frame_feeder: RTL and testbench

- Parallel-to-serial stage placed directly upstream of the 4-bit shift-register sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on SO, which drives the detector's SI input.
- Consecutive words stream with no idle gap, so a bit pattern can be detected across a word boundary.
- Also reports frame progress (bit_valid, last_bit, busy) to the surrounding control logic.

---
 rtl/serial_frame_feeder.sv | 113 +++++++++++
 tb/tb_serial_frame_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_feeder.sv
// serial_frame_feeder: parallel-to-serial stage ahead of the serial sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on SO. The
// final bit of a word can overlap with the accept of the next one, so consecutive words
// stream with no idle gap and a detector can match patterns that span a word boundary.
module serial_frame_feeder #(
    parameter int unsigned WIDTH     = 8,    // bits per word, 2..32
    parameter bit          MSB_FIRST = 1'b1, // 1: data_in[WIDTH-1] leaves first
    parameter bit          IDLE_BIT  = 1'b0  // SO level while no bit is valid
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             SO,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned           CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]       CntLast = CntW'(WIDTH - 1);
    // Register bit that is presented on SO.
    localparam int unsigned           OutIdx  = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             at_last;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;

    // Handshake: ready while idle, or while the last bit is on SO (zero-bubble reload).
    always_comb begin
        at_last    = (state_q == StShift) && (cnt_q == CntLast);
        load_ready = !rst && ((state_q == StIdle) || at_last);
        accept     = load_valid && load_ready;
    end

    // Shift toward the output bit; the vacated position fills with 0.
    always_comb begin
        shreg_shifted = '0;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load on accept, otherwise advance until the last bit then go idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    shreg_d = data_in;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (accept) begin
                    // Only possible on the last bit: back-to-back reload.
                    state_d = StShift;
                    shreg_d = data_in;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = StIdle;
                    shreg_d = shreg_shifted;
                    cnt_d   = '0;
                end else begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, shift register and bit counter; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from registers, so SO is stable for the whole cycle.
    always_comb begin
        bit_valid = (state_q == StShift);
        busy      = bit_valid;
        last_bit  = at_last;
        SO        = bit_valid ? shreg_q[OutIdx] : IDLE_BIT;
    end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Self-checking bench for serial_frame_feeder: one MSB-first and one LSB-first instance
// share the same stimulus. A reference model turns every accepted word into its bit
// stream in a queue; a monitor pops one expected bit per cycle and compares.
module tb_serial_frame_feeder;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load_valid;

    logic rdy_m, so_m, bv_m, lb_m, busy_m;
    logic rdy_l, so_l, bv_l, lb_l, busy_l;

    int errors = 0;
    int checks = 0;

    exp_t q_m[$];
    exp_t q_l[$];

    serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .SO         (so_m),
        .bit_valid  (bv_m),
        .last_bit   (lb_m),
        .busy       (busy_m)
    );

    serial_frame_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .SO         (so_l),
        .bit_valid  (bv_l),
        .last_bit   (lb_l),
        .busy       (busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is taken when valid is high and nothing of the previous
    // word remains beyond the bit currently on SO (already popped by the monitor).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else if (load_valid && q_m.size() == 0) begin
            for (int k = 0; k < W; k++) begin
                q_m.push_back('{b: data_in[W-1-k], last: (k == W - 1)});
                q_l.push_back('{b: data_in[k], last: (k == W - 1)});
            end
        end
    end

    task automatic check_lane(input string tag, input logic so, input logic bv, input logic lb,
                              input logic rdy, input logic by, input int qsize,
                              input exp_t head);
        if (rst) begin
            chk({tag, "_rst_so"}, so, 0);
            chk({tag, "_rst_valid"}, bv, 0);
            chk({tag, "_rst_last"}, lb, 0);
            chk({tag, "_rst_ready"}, rdy, 0);
            chk({tag, "_rst_busy"}, by, 0);
        end else if (qsize > 0) begin
            chk({tag, "_so"}, so, head.b);
            chk({tag, "_valid"}, bv, 1);
            chk({tag, "_last"}, lb, head.last);
            chk({tag, "_ready"}, rdy, (qsize == 1));
            chk({tag, "_busy"}, by, 1);
        end else begin
            chk({tag, "_idle_so"}, so, 0);
            chk({tag, "_idle_valid"}, bv, 0);
            chk({tag, "_idle_last"}, lb, 0);
            chk({tag, "_idle_ready"}, rdy, 1);
            chk({tag, "_idle_busy"}, by, 0);
        end
    endtask

    // Monitor: sample mid-cycle, compare against the head of each queue, then consume it.
    always @(negedge clk) begin
        exp_t hm, hl;
        int   sm, sl;
        hm = '0;
        hl = '0;
        sm = q_m.size();
        sl = q_l.size();
        if (sm > 0) hm = q_m[0];
        if (sl > 0) hl = q_l[0];
        check_lane("msb", so_m, bv_m, lb_m, rdy_m, busy_m, sm, hm);
        check_lane("lsb", so_l, bv_l, lb_l, rdy_l, busy_l, sl, hl);
        if (!rst && sm > 0) void'(q_m.pop_front());
        if (!rst && sl > 0) void'(q_l.pop_front());
    end

    // Present a word and hold it until accepted; optionally scramble data_in while stalled.
    task automatic send(input logic [W-1:0] w, input bit scramble);
        bit got;
        int n;
        load_valid = 1'b1;
        data_in    = w;
        n          = 0;
        got        = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = rdy_m;
            @(posedge clk);
            #1;
            n++;
            if (!got && scramble && $urandom_range(0, 2) == 0) data_in = W'($urandom);
        end
        chk("send_accepted", got, 1);
        load_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = W'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held for two cycles with a word already offered.
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hE7;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", rdy_m, 0);
        chk("reset_valid", bv_m, 0);
        chk("reset_so", so_m, 0);
        rst = 1'b0;
        send(8'hE7, 1'b0);
        idle(10);

        // LSB-first lane sees 0x0B as 1,1,0,1,0,0,0,0.
        send(8'h0B, 1'b0);
        idle(10);

        // Back-to-back words: no bubble between them.
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        idle(10);

        // Stall: request at cnt=2, change data before cnt=7; the last value is captured.
        send(8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_ready_cnt2", rdy_m, 0);
        load_valid = 1'b1;
        data_in    = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        send(8'hC3, 1'b0);
        idle(10);

        // Mid-word reset: outputs clear asynchronously, word is abandoned.
        send(8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid_m", bv_m, 0);
        chk("async_rst_so_m", so_m, 0);
        chk("async_rst_last_m", lb_m, 0);
        chk("async_rst_valid_l", bv_l, 0);
        chk("async_rst_ready", rdy_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Random words, random gaps, data_in scrambled while stalled.
        for (int i = 0; i < 60; i++) begin
            send(W'($urandom), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(12);
        chk("drain_msb", q_m.size(), 0);
        chk("drain_lsb", q_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
